// File: rtl/logic_op_pipe.sv
//============================================================================
// Module   : logic_op_pipe
// Brief    : Bitwise AND/OR/XOR/NAND unit behind a 2-entry in-order result
//            buffer with valid/ready handshakes and a saturating result count.
// Revision : 1.0
//============================================================================
`default_nettype none

module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_nz,
  output logic [1:0]       y_op,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [1:0]       c_depth   = 2'd2;

  logic [WIDTH-1:0] r_data [2];
  logic             r_nz   [2];
  logic [1:0]       r_op   [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;
  logic             r_active;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_result;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_result = '0;
    case (op)
      2'b00:   w_result = a & b;
      2'b01:   w_result = a | b;
      2'b10:   w_result = a ^ b;
      default: w_result = ~(a & b);
    endcase
  end

  // r_active holds in_ready low until the first edge after reset release.
  assign in_ready  = r_active && (r_occ != c_depth);
  assign out_valid = (r_occ != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_nz[i]   <= 1'b0;
        r_op[i]   <= 2'b00;
      end
    end else if (w_push) begin
      r_data[r_wptr] <= w_result;
      r_nz[r_wptr]   <= |w_result;
      r_op[r_wptr]   <= op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_pop && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Storage is cleared by reset, so the head reads zero while empty after reset.
  assign y        = r_data[r_rptr];
  assign y_nz     = r_nz[r_rptr];
  assign y_op     = r_op[r_rptr];
  assign op_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
//============================================================================
// Module   : tb_logic_op_pipe
// Brief    : Self-checking bench for logic_op_pipe against a queue-based model.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_logic_op_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       y_nz;
  logic [1:0] y_op;
  logic [3:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic_op_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_nz(y_nz), .y_op(y_op), .op_count(op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] y;
    logic       nz;
    logic [1:0] op;
  } ent_t;

  ent_t mq[$];
  int   mcnt;
  bit   mact;

  function automatic ent_t ref_ent(input logic [7:0] ra, input logic [7:0] rb, input logic [1:0] rop);
    ent_t e;
    case (rop)
      2'b00:   e.y = ra & rb;
      2'b01:   e.y = ra | rb;
      2'b10:   e.y = ra ^ rb;
      default: e.y = ~(ra & rb);
    endcase
    e.nz = (e.y != 8'h00);
    e.op = rop;
    return e;
  endfunction

  // Reference: a FIFO of at most two results plus a saturating delivery count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
      mact = 0;
    end else begin
      bit acc;
      bit hnd;
      acc = mact && in_valid && (mq.size() < 2);
      hnd = (mq.size() > 0) && out_ready;
      if (hnd) begin
        void'(mq.pop_front());
        if (mcnt < 15) mcnt++;
      end
      if (acc) mq.push_back(ref_ent(a, b, op));
      mact = 1;
    end
  end

  task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                       input logic [1:0] dop, input logic ordy);
    in_valid  = v;
    a         = da;
    b         = db;
    op        = dop;
    out_ready = ordy;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    #3;
    n_cmp++; if ({in_ready, out_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_hs: in_ready/out_valid=%b required 00", {in_ready, out_valid}); end
    n_cmp++; if ({y, y_nz, y_op, op_count} !== 15'd0) begin n_bad++; $display("FAIL reset_data: y=%h y_nz=%b y_op=%b cnt=%h required all 0", y, y_nz, y_op, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_release_early: in_ready=%b required 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_edge: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_ops_sweep();
    logic [7:0] exp_y [4];
    exp_y = '{8'h88, 8'hEE, 8'h66, 8'h77};
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if ({out_valid, y, y_nz, y_op} !== {1'b1, exp_y[i-1], 1'b1, 2'(i-1)})
          begin n_bad++; $display("FAIL ops_sweep%0d: v=%b y=%h nz=%b op=%b required y=%h op=%0d", i-1, out_valid, y, y_nz, y_op, exp_y[i-1], i-1); end
      end
      if (i < 4) drive(1'b1, 8'hCC, 8'hAA, 2'(i), 1'b1);
      else       drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ops_drain: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_zero_result();
    @(negedge clk);
    drive(1'b1, 8'h0F, 8'hF0, 2'b00, 1'b1);
    @(negedge clk);
    n_cmp++; if ({out_valid, y, y_nz} !== {1'b1, 8'h00, 1'b0}) begin n_bad++; $display("FAIL zero_result: v=%b y=%h nz=%b required v=1 y=00 nz=0", out_valid, y, y_nz); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(1'b1, 8'd1, 8'd0, 2'b01, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_one_entry: in_ready=%b required 1", in_ready); end
    drive(1'b1, 8'd2, 8'd0, 2'b01, 1'b0);
    @(negedge clk);
    n_cmp++; if ({in_ready, out_valid, y} !== {1'b0, 1'b1, 8'd1}) begin n_bad++; $display("FAIL bp_full: in_ready=%b v=%b y=%h required 0 1 01", in_ready, out_valid, y); end
    drive(1'b1, 8'd3, 8'd0, 2'b01, 1'b0);
    @(negedge clk);
    n_cmp++; if ({in_ready, y, y_op} !== {1'b0, 8'd1, 2'b01}) begin n_bad++; $display("FAIL bp_stable: in_ready=%b y=%h op=%b required 0 01 01", in_ready, y, y_op); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({in_ready, y} !== {1'b1, 8'd2}) begin n_bad++; $display("FAIL bp_second: in_ready=%b y=%h required 1 02", in_ready, y); end
    @(negedge clk);
    n_cmp++; if ({out_valid, y} !== {1'b1, 8'd3}) begin n_bad++; $display("FAIL bp_third: v=%b y=%h required 1 03", out_valid, y); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_saturation();
    int hand;
    int want;
    pulse_reset();
    hand = 0;
    for (int i = 0; i < 22; i++) begin
      want = (hand > 15) ? 15 : hand;
      n_cmp++; if (op_count !== 4'(want)) begin n_bad++; $display("FAIL sat_count%0d: op_count=%0d required %0d", hand, op_count, want); end
      drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1);
      if (mq.size() > 0) hand++;
      @(negedge clk);
    end
    n_cmp++; if (op_count !== 4'hF) begin n_bad++; $display("FAIL sat_final: op_count=%h required F after %0d handoffs", op_count, hand); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    bit   reached;
    ent_t first;
    logic [7:0] fa, fb;
    logic [1:0] fop;
    pulse_reset();
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (mcnt == 5 && mq.size() == 2) reached = 1;
      else begin
        drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), (mcnt < 5));
        @(negedge clk);
      end
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL mid_setup: model count=%0d occ=%0d required 5 and 2", mcnt, mq.size()); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    n_cmp++; if ({op_count, in_ready, out_valid} !== {4'd5, 1'b0, 1'b1}) begin n_bad++; $display("FAIL mid_pre: cnt=%0d in_ready=%b v=%b required 5 0 1", op_count, in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid, y, y_nz, y_op, op_count} !== 17'd0) begin n_bad++; $display("FAIL mid_reset: rdy=%b v=%b y=%h nz=%b op=%b cnt=%h required all 0", in_ready, out_valid, y, y_nz, y_op, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    fa = 8'($urandom); fb = 8'($urandom); fop = 2'($urandom);
    first = ref_ent(fa, fb, fop);
    drive(1'b1, fa, fb, fop, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({out_valid, y, y_nz, y_op} !== {1'b1, first}) begin n_bad++; $display("FAIL mid_first: v=%b y=%h nz=%b op=%b required y=%h nz=%b op=%b", out_valid, y, y_nz, y_op, first.y, first.nz, first.op); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    ent_t prev;
    logic [7:0] da, db;
    logic [1:0] dop;
    da = 8'($urandom); db = 8'($urandom); dop = 2'($urandom);
    prev = ref_ent(da, db, dop);
    drive(1'b1, da, db, dop, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({in_ready, out_valid, y, y_nz, y_op} !== {2'b11, prev}) begin n_bad++; $display("FAIL b2b%0d: rdy=%b v=%b y=%h nz=%b op=%b required 1 1 y=%h", i, in_ready, out_valid, y, y_nz, y_op, prev.y); end
      da = 8'($urandom); db = 8'($urandom); dop = 2'($urandom);
      prev = ref_ent(da, db, dop);
      drive(1'b1, da, db, dop, 1'b1);
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    n_cmp++; if ({out_valid, y} !== {1'b1, prev.y}) begin n_bad++; $display("FAIL b2b_last: v=%b y=%h required 1 %h", out_valid, y, prev.y); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 9) < 6));
      #1;
      exp_rdy = mact && (mq.size() < 2);
      n_cmp++; if ({in_ready, out_valid, op_count} !== {exp_rdy, (mq.size() > 0), 4'(mcnt)}) begin n_bad++; $display("FAIL rand_ctl%0d: rdy=%b v=%b cnt=%0d required %b %b %0d", i, in_ready, out_valid, op_count, exp_rdy, (mq.size() > 0), mcnt); end
      if (mq.size() > 0) begin
        n_cmp++; if ({y, y_nz, y_op} !== mq[0]) begin n_bad++; $display("FAIL rand_data%0d: y=%h nz=%b op=%b required y=%h nz=%b op=%b", i, y, y_nz, y_op, mq[0].y, mq[0].nz, mq[0].op); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ops_sweep();
    test_zero_result();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_op_pipe.md
LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand and result width in bits (legal: 1..64).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the completed-operation counter (legal: 4..32).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  an operand set (a, b, op) is presented.
REQ-007 in_ready  output  1  the block can accept an operand set this cycle.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND (all bitwise).
REQ-011 out_valid  output  1  y, y_nz and y_op hold a valid result.
REQ-012 out_ready  input  1  the consumer takes the result this cycle.
REQ-013 y  output  WIDTH  bitwise result of the head entry.
REQ-014 y_nz  output  1  reduction-OR of y for the head entry.
REQ-015 y_op  output  2  op value that produced the head entry.
REQ-016 op_count  output  CNT_W  number of results delivered, saturating.

Function
REQ-017 Input accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; output handoff SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-018 The result SHALL be computed from a, b and op at accept and stored with y_nz and op in a 2-entry in-order result buffer; the combinational path from inputs to outputs SHALL NOT exist.
REQ-019 in_ready SHALL be 1 if and only if the buffer holds fewer than 2 entries, and SHALL depend on registered state only, not on out_ready.
REQ-020 out_valid SHALL be 1 if and only if the buffer holds at least 1 entry; y, y_nz and y_op SHALL present the oldest entry.
REQ-021 Latency: an operand set accepted at edge N into an empty buffer SHALL appear with out_valid=1 after edge N.
REQ-022 Throughput: with out_ready held at 1, one result per cycle SHALL be sustained indefinitely.
REQ-023 Simultaneous accept and handoff SHALL leave the occupancy unchanged and preserve order.
REQ-024 When the buffer is full, in_valid SHALL be ignored and a, b and op SHALL NOT be sampled.
REQ-025 Handoff on an empty buffer (out_ready=1, out_valid=0) SHALL have no effect.
REQ-026 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 op_count SHALL increment by 1 on each handoff and hold at 2^CNT_W-1 once reached, with no wrap-around.
REQ-028 Buffer storage SHALL wrap its read and write pointers modulo 2.

Reset
REQ-029 While rst_n=0: in_ready=0, out_valid=0, y=0, y_nz=0, y_op=00, op_count=0, and the buffer SHALL be empty, with effect immediate and independent of clk.
REQ-030 in_ready SHALL rise to 1 on the first rising edge after rst_n deasserts.
REQ-031 A reset asserted mid-operation SHALL discard all buffered entries; no pre-reset result SHALL appear afterwards.

Verification (WIDTH=8, CNT_W=4)
REQ-032 Ops sweep: a=8'hCC, b=8'hAA, op=00/01/10/11 with out_ready=1 -> y=8'h88/8'hEE/8'h66/8'h77 on consecutive cycles, each with y_nz=1 and y_op matching.
REQ-033 Zero result: a=8'h0F, b=8'hF0, op=00 -> y=8'h00, y_nz=0.
REQ-034 Backpressure: out_ready=0 with 3 input offers of values 1, 2, 3 -> in_ready=0 after 2 accepts and y stable at result 1; out_ready=1 then delivers results 1 and 2 in order, then value 3 is accepted.
REQ-035 Saturation: 20 handoffs -> op_count reaches 4'hF at handoff 15 and stays at 4'hF.
REQ-036 Reset mid-stream: buffer holds 2 entries and op_count=5, then rst_n pulses low between edges -> all outputs become 0 immediately, and after release the first result seen is the first post-reset input.
REQ-037 Simultaneous push and pop with 1 entry and both handshakes active for 10 cycles -> occupancy stays at 1, in_ready and out_valid stay at 1, and the output sequence matches the input sequence delayed by one.
